// File: rtl/ahb_pkg.sv
// Shared types and constants for the AHB-Lite master bridge.
//   htrans_t       : the two transfer types the bridge ever issues
//   bridge_state_t : bridge FSM states
//   bus_req_t      : CPU request captured at acceptance
package ahb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    // Word alignment: bus address bits [1:0] are always zero
    localparam logic [ADDR_W-1:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } bridge_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              write;
    } bus_req_t;

endpackage

// File: rtl/ahb_master_bridge.sv
// Single-word CPU memory request -> one AHB-Lite transfer.
// Ports:
//   HCLK, HRESETn                 clock, async active-low reset
//   mem_req/write/addr/wdata      CPU request (level, held until mem_done)
//   mem_rdata/done/err            CPU completion (done is a one-cycle pulse)
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA  AHB-Lite master outputs
//   HRDATA/HREADY/HRESP           AHB-Lite slave response
// A wait counter bounds HREADY-low stalls per phase; expiry completes the
// request with mem_err=1 so a dead slave cannot hang the CPU.
module ahb_master_bridge
    import ahb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    bridge_state_t     state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    bus_req_t          req_q,    req_d;
    htrans_t           htrans_q, htrans_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;

    logic [CNT_W-1:0]  cnt_inc_c;
    logic              timeout_c;

    // Saturating increment; the counter never wraps
    assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_c = (cnt_q >= CNT_LAST);

    // State register and registered outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            htrans_q <= htrans_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        htrans_d = htrans_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                htrans_d = HTRANS_IDLE;
                if (mem_req) begin
                    req_d.addr  = mem_addr & WORD_ADDR_MASK;
                    req_d.wdata = mem_wdata;
                    req_d.write = mem_write;
                    htrans_d    = HTRANS_NONSEQ;
                    cnt_d       = '0;
                    state_d     = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = req_q.wdata;
                    cnt_d    = '0;
                    state_d  = ST_DATA;
                end else if (timeout_c) begin
                    htrans_d = HTRANS_IDLE;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end

            ST_DATA: begin
                // ERROR beats timeout; HREADY=1 beats timeout
                if (HRESP == HRESP_ERROR) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (HREADY && (HRESP == HRESP_OKAY)) begin
                    if (!req_q.write) begin
                        rdata_d = HRDATA;
                    end
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (timeout_c) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end

            ST_DONE: begin
                // mem_req ignored here; the CPU drops it during this cycle
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                htrans_d = HTRANS_IDLE;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    assign HADDR     = req_q.addr;
    assign HWRITE    = req_q.write;
    assign HTRANS    = htrans_q;
    assign HSIZE     = HSIZE_WORD;
    assign HWDATA    = hwdata_q;
    assign mem_rdata = rdata_q;
    assign mem_done  = done_q;
    assign mem_err   = err_q;

endmodule
